led_pattern_ctrl: RTL and testbench
===================================

# led_pattern_ctrl

Parametrised LED pattern generator, the successor to the fixed two-LED half-second blinker. It drives `LED_NUM` outputs from one system clock. It supports four run-time selectable patterns (blink, flow, bounce, fill), a 4-level step-speed select and a run/pause control. It sits directly behind the board LED pins. The `step` strobe output lets neighbouring blocks (buzzer, seven-segment) stay in sync with the pattern.

## Interface
- `LED_NUM`, 4: number of LED outputs; legal range 2..32.
- `TICK_CNT`, 12_500_000: base tick period in clocks (0.25 s at 50 MHz). Benches override it to a small value such as 4.
- `CNT_W`, 24: prescaler width; must satisfy 2^CNT_W >= TICK_CNT.
- `sys_clk`  in  1  system clock; all logic is on its rising edge.
- `sys_rst_n`  in  1  asynchronous, active-low reset.
- `run`  in  1  1 = pattern advances; 0 = freeze counters and LEDs.
- `mode`  in  2  pattern select: 00 blink, 01 flow, 10 bounce, 11 fill.
- `speed`  in  2  base ticks per step minus one; step period = (speed+1)·TICK_CNT.
- `led`  out  LED_NUM  LED drive, registered, active-high.
- `step`  out  1  one-cycle strobe, high in the cycle in which `led` takes a new value.

## Operation
- **Prescaler `cnt`** (CNT_W bits):
  - when run=1, counts 0..TICK_CNT-1 and wraps;
  - `base_tick` = run && (cnt == TICK_CNT-1).
- **Sub-counter `sub`** (2 bits):
  - on base_tick, if sub >= speed then sub <= 0 and a step fires; otherwise sub <= sub+1;
  - the >= comparison makes a live decrease of `speed` take effect at the next base tick, with no 4-tick overrun.
- **Pause (run=0):** cnt, sub, led, internal direction and mode registers all hold; step=0. Resume continues from the held counts.
- **Mode register `mode_r`** (reset 00). At each step:
  - if mode != mode_r, then mode_r <= mode, led loads the init pattern of the new mode, and dir <= up;
  - otherwise led advances per mode_r.
  - Mode changes are therefore applied only on step boundaries.
- **Init patterns:** blink = all ones; flow, bounce and fill = 0…01.
- **Advance rules** (dir: up = toward MSB):
  - **blink:** led <= ~led.
  - **flow:** rotate left, led <= {led[N-2:0], led[N-1]}; period N.
  - **bounce:** one-hot moves in direction dir.
    - At led[N-1]=1 while dir=up: dir <= down and shift right.
    - At led[0]=1 while dir=down: dir <= up and shift left.
    - Period 2N-2; the end LEDs are lit once per pass.
  - **fill:** thermometer code.
    - dir=up: led <= {led[N-2:0],1}. On reaching all ones: dir <= down.
    - dir=down: led <= led>>1. On reaching 0…01: dir <= up.
    - Period 2N-2.
- **Reset values:** led = 0, step = 0, cnt = 0, sub = 0, mode_r = 00, dir = up.
  - First step with mode=00 gives all ones (00 toggles to 11…1).
  - First step with any other mode loads that mode's init pattern.
- **Mid-operation reset** asynchronously clears everything immediately; there is no partial pattern after release.

## Timing
- With run=1 from reset release, `led` and `step` first change on rising edge number (speed+1)·TICK_CNT after release; edges are counted from 1.
- Subsequent steps occur every (speed+1)·TICK_CNT clocks while run=1 and speed is constant.
- `led` has zero-cycle latency relative to `step`: both update on the same edge, and step is high for exactly one cycle.
- run falling in the same cycle as a would-be base_tick suppresses that tick; the step then fires after the remaining clocks once run returns.
- mode and speed are sampled only at base_tick/step edges. Inputs are expected to be synchronous or already debounced.

## Test plan
All scenarios use TICK_CNT=4 and LED_NUM=4.
- **Blink default:** mode=00, speed=0, run=1 from reset. led = 0000 until edge 4, then 1111 at 4, 0000 at 8, 1111 at 12. step is high only at 4, 8, 12.
- **Flow at speed 2:** mode=01, speed=2. led = 0001 at edge 12, then 0010 at 24, 0100 at 36, 1000 at 48, 0001 at 60.
- **Bounce and fill, speed 0:** bounce gives 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010. Fill gives 0001, 0011, 0111, 1111, 0111, 0011, 0001, 0011.
- **Mode change mid-pattern:** while in bounce at 0100 with dir=down, switch mode to 11 between steps. The next step yields 0001 (fill init) and the following step yields 0011.
- **Pause:** run=0 for 10 cycles in the middle of a period. led is held, step stays 0, and the next step is delayed by exactly 10 cycles.
- **Speed decrease and reset:**
  - With speed=3 and sub=2, set speed=0: the step fires at the next base tick.
  - Assert sys_rst_n=0 mid-step: led goes to 0000 asynchronously and restarts as in the blink-default scenario.

Source files
------------

// File: rtl/led_pattern_ctrl.sv
// LED pattern generator: blink, flow, bounce and fill patterns stepped by a
// prescaled tick, with run/pause control, selectable step speed and a step strobe.
module led_pattern_ctrl #(
    parameter int LED_NUM  = 4,
    parameter int TICK_CNT = 12_500_000,
    parameter int CNT_W    = 24
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic               run,
    input  logic [1:0]         mode,
    input  logic [1:0]         speed,
    output logic [LED_NUM-1:0] led,
    output logic               step
);

    typedef enum logic [1:0] {
        MODE_BLINK  = 2'b00,
        MODE_FLOW   = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_FILL   = 2'b11
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    localparam logic [CNT_W-1:0]   TICK_LAST = CNT_W'(TICK_CNT - 1);
    localparam logic [LED_NUM-1:0] ONES      = '1;
    localparam logic [LED_NUM-1:0] LSB_ONLY  = LED_NUM'(1);

    logic [CNT_W-1:0]   cnt_q,  cnt_d;
    logic [1:0]         sub_q,  sub_d;
    logic [LED_NUM-1:0] led_q,  led_d;
    dir_e               dir_q,  dir_d;
    mode_e              mode_q, mode_d;
    logic               step_q;

    logic  base_tick;
    logic  step_fire;
    mode_e mode_in;

    assign mode_in   = mode_e'(mode);
    assign base_tick = run && (cnt_q == TICK_LAST);
    // >= rather than == lets a live speed decrease take effect at the next tick.
    assign step_fire = base_tick && (sub_q >= speed);

    always_comb begin
        // NOTE: every comb output gets a default first so no path infers a latch.
        cnt_d = cnt_q;
        sub_d = sub_q;
        if (run) begin
            cnt_d = base_tick ? '0 : cnt_q + 1'b1;
        end
        if (base_tick) begin
            sub_d = step_fire ? 2'd0 : sub_q + 2'd1;
        end
    end

    always_comb begin
        led_d  = led_q;
        dir_d  = dir_q;
        mode_d = mode_q;
        if (step_fire) begin
            if (mode_in != mode_q) begin
                mode_d = mode_in;
                dir_d  = DIR_UP;
                led_d  = (mode_in == MODE_BLINK) ? ONES : LSB_ONLY;
            end else begin
                unique case (mode_q)
                    MODE_BLINK: led_d = ~led_q;
                    MODE_FLOW:  led_d = {led_q[LED_NUM-2:0], led_q[LED_NUM-1]};
                    MODE_BOUNCE: begin
                        // Turn around on the end LED so each end is lit once per pass.
                        if (dir_q == DIR_UP) begin
                            if (led_q[LED_NUM-1]) begin
                                dir_d = DIR_DOWN;
                                led_d = led_q >> 1;
                            end else begin
                                led_d = led_q << 1;
                            end
                        end else begin
                            if (led_q[0]) begin
                                dir_d = DIR_UP;
                                led_d = led_q << 1;
                            end else begin
                                led_d = led_q >> 1;
                            end
                        end
                    end
                    MODE_FILL: begin
                        if (dir_q == DIR_UP) begin
                            led_d = {led_q[LED_NUM-2:0], 1'b1};
                            if (led_d == ONES) dir_d = DIR_DOWN;
                        end else begin
                            led_d = led_q >> 1;
                            if (led_d == LSB_ONLY) dir_d = DIR_UP;
                        end
                    end
                    default: led_d = led_q;
                endcase
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_q  <= '0;
            sub_q  <= '0;
            led_q  <= '0;
            dir_q  <= DIR_UP;
            mode_q <= MODE_BLINK;
            step_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sub_q  <= sub_d;
            led_q  <= led_d;
            dir_q  <= dir_d;
            mode_q <= mode_d;
            step_q <= step_fire;
        end
    end

    assign led  = led_q;
    assign step = step_q;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Scoreboard bench for led_pattern_ctrl: a pattern-index model predicts each step's
// edge and LED value; a monitor checks every strobe and that LEDs hold between steps.
module tb_led_pattern_ctrl;

    localparam int N    = 4;
    localparam int TICK = 4;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         run   = 1'b0;
    logic [1:0]   mode  = 2'b00;
    logic [1:0]   speed = 2'b00;
    logic [N-1:0] led;
    logic         step;

    led_pattern_ctrl #(.LED_NUM(N), .TICK_CNT(TICK), .CNT_W(8)) dut (
        .sys_clk  (clk),
        .sys_rst_n(rst_n),
        .run      (run),
        .mode     (mode),
        .speed    (speed),
        .led      (led),
        .step     (step)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           edge_no;
        logic [N-1:0] led;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   edge_cnt;

    // Reference model: patterns from a phase index, not from shift registers.
    int           m_active, m_sub, m_mode, m_k;
    bit           m_b;
    logic [N-1:0] m_led;
    logic [N-1:0] last_led;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    function automatic logic [N-1:0] pattern(input int md, input int k, input bit b);
        int p, pos, lit;
        p = k % (2*N - 2);
        case (md)
            0: return b ? {N{1'b1}} : {N{1'b0}};
            1: return N'(1 << (k % N));
            2: begin
                pos = (p < N) ? p : 2*N - 2 - p;
                return N'(1 << pos);
            end
            default: begin
                lit = (p < N) ? p + 1 : 2*N - 1 - p;
                return N'((1 << lit) - 1);
            end
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edge_cnt <= 0;
        else        edge_cnt <= edge_cnt + 1;
    end

    // Model: decide at the falling edge what the next rising edge will do.
    always @(negedge clk) begin
        if (!rst_n) begin
            m_active = 0; m_sub = 0; m_mode = 0; m_k = 0; m_b = 0; m_led = '0;
            q.delete();
        end else if (run) begin
            m_active++;
            if (m_active % TICK == 0) begin
                if (m_sub >= int'(speed)) begin
                    m_sub = 0;
                    if (int'(mode) != m_mode) begin
                        m_mode = int'(mode); m_k = 0; m_b = 1;
                    end else begin
                        m_k++; m_b = !m_b;
                    end
                    m_led = pattern(m_mode, m_k, m_b);
                    q.push_back('{edge_cnt + 1, m_led});
                end else begin
                    m_sub++;
                end
            end
        end
    end

    // Monitor: pops on each strobe, otherwise requires the LEDs to hold.
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            last_led = '0;
        end else begin
            while (q.size() > 0 && q[0].edge_no < edge_cnt) begin
                check("missed_step_edge", edge_cnt, q[0].edge_no);
                void'(q.pop_front());
            end
            if (step) begin
                if (q.size() == 0) begin
                    check("spurious_step", 1, 0);
                end else if (q[0].edge_no != edge_cnt) begin
                    check("step_edge", edge_cnt, q[0].edge_no);
                end else begin
                    check("step_led", led, q[0].led);
                    void'(q.pop_front());
                end
            end else begin
                check("led_hold", led, last_led);
            end
            last_led = led;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_step(input string name, input int bound);
        bit found = 0;
        for (int i = 0; i < bound; i++) begin
            @(posedge clk);
            #1;
            if (step) begin found = 1; break; end
        end
        #1;
        if (!found) check({name, "_timeout"}, 0, 1);
    endtask

    initial begin
        int waited;
        bit hit;

        // Reset state, then blink default from release.
        rst_n = 1'b0; run = 1'b1; mode = 2'b00; speed = 2'b00;
        repeat (3) @(posedge clk);
        #2;
        check("reset_led", led, 0);
        check("reset_step", step, 0);
        rst_n = 1'b1;
        wait_step("blink_first", 20);
        check("blink_first_edge", edge_cnt, 4);
        check("blink_first_led", led, 4'b1111);
        cyc(10);

        // Flow at speed 2, then bounce and fill at speed 0.
        mode = 2'b01; speed = 2'd2;
        cyc(70);
        mode = 2'b10; speed = 2'd0;
        cyc(40);
        mode = 2'b11;
        cyc(40);

        // Bounce at 0100 heading down, then switch to fill between steps.
        mode = 2'b10;
        hit = 0;
        for (int i = 0; i < 200; i++) begin
            cyc(1);
            if (m_mode == 2 && m_k % 6 == 4) begin hit = 1; break; end
        end
        check("bounce_reach_down", hit, 1);
        check("bounce_at_0100", led, 4'b0100);
        mode = 2'b11;
        wait_step("fill_init", 20);
        check("fill_init_led", led, 4'b0001);
        wait_step("fill_next", 20);
        check("fill_next_led", led, 4'b0011);

        // Pause for 10 cycles mid-period.
        mode = 2'b01; speed = 2'd1;
        wait_step("pause_sync", 20);
        cyc(3);
        run = 1'b0;
        cyc(10);
        run = 1'b1;
        cyc(30);

        // Speed decrease from 3 to 0 with sub at 2.
        speed = 2'd3;
        hit = 0;
        for (int i = 0; i < 100; i++) begin
            cyc(1);
            if (m_sub == 2) begin hit = 1; break; end
        end
        check("sub_reach_2", hit, 1);
        speed = 2'd0;
        waited = edge_cnt;
        wait_step("speed_drop", 20);
        check("speed_drop_latency_ok", (edge_cnt - waited) <= TICK, 1);

        // Mid-step asynchronous reset, then blink default again.
        wait_step("pre_reset", 40);
        rst_n = 1'b0;
        #1;
        check("async_reset_led", led, 0);
        check("async_reset_step", step, 0);
        mode = 2'b00; speed = 2'd0;
        cyc(3);
        rst_n = 1'b1;
        wait_step("blink_restart", 20);
        check("blink_restart_edge", edge_cnt, 4);
        check("blink_restart_led", led, 4'b1111);

        // Random run/mode/speed traffic.
        for (int i = 0; i < 600; i++) begin
            cyc(1);
            if ($urandom_range(0, 9) == 0) run   = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) mode  = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) speed = 2'($urandom_range(0, 3));
        end
        run = 1'b1;
        cyc(4 * TICK + 4);
        check("queue_drained", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
